// File: rtl/axi_fifo_pkg.sv
// Shared widths and the message type for the dummy AXI FIFO shim.
// Count width is sized to hold 0..DEPTH inclusive.
package axi_fifo_pkg;

  localparam int W_MSG_DFLT = 64;
  localparam int DEPTH_DFLT = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W_DFLT = cnt_w(DEPTH_DFLT);

  typedef logic [W_MSG_DFLT-1:0] msg_t;

endpackage

// File: rtl/msg_fifo.sv
// Synchronous FIFO: push-with-ack (one ack pulse per accepted word, no push while ack high),
// pop on consumer ack. Head visible the cycle after push; full stalls push on pre-edge count.
module msg_fifo
  import axi_fifo_pkg::*;
#(
  parameter int W     = W_MSG_DFLT,
  parameter int DEPTH = DEPTH_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_rdy,
  input  logic [W-1:0]             push_dat,
  output logic                     push_ack,
  output logic                     pop_rdy,
  output logic [W-1:0]             pop_dat,
  input  logic                     pop_ack,
  output logic [cnt_w(DEPTH)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          full, empty, do_push, do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    // ack_q gates the push so a producer that drops rdy a cycle late is not written twice
    do_push  = push_rdy && !ack_q && !full;
    do_pop   = pop_ack && !empty;
    ack_d    = do_push;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
    end
  end

  assign push_ack = ack_q;
  assign pop_rdy  = !empty;
  assign pop_dat  = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = count_q;

endmodule

// File: rtl/axi_fifo_dummy_core.sv
// Message shim: inbound (outside->controller) and outbound (controller->outside) FIFOs, fully independent.
// AXI_FIFO_DUMMY_LEVEL_EN adds in_level/out_level entry-count outputs.
module axi_fifo_dummy_core
  import axi_fifo_pkg::*;
#(
  parameter int W_MSG = W_MSG_DFLT,
  parameter int DEPTH = DEPTH_DFLT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    o_in_msg_rdy,
  input  logic [W_MSG-1:0]        o_in_msg,
  output logic                    o_in_msg_ack,
  output logic                    i_in_msg_rdy,
  output logic [W_MSG-1:0]        i_in_msg,
  input  logic                    i_in_msg_ack,
  input  logic                    i_out_msg_rdy,
  input  logic [W_MSG-1:0]        i_out_msg,
  output logic                    i_out_msg_ack,
  output logic                    o_out_msg_rdy,
  output logic [W_MSG-1:0]        o_out_msg,
  input  logic                    o_out_msg_ack
`ifdef AXI_FIFO_DUMMY_LEVEL_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] in_level,
  output logic [cnt_w(DEPTH)-1:0] out_level
`endif
);

  logic [cnt_w(DEPTH)-1:0] in_cnt;
  logic [cnt_w(DEPTH)-1:0] out_cnt;

  msg_fifo #(.W(W_MSG), .DEPTH(DEPTH)) u_in_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_rdy (o_in_msg_rdy),
    .push_dat (o_in_msg),
    .push_ack (o_in_msg_ack),
    .pop_rdy  (i_in_msg_rdy),
    .pop_dat  (i_in_msg),
    .pop_ack  (i_in_msg_ack),
    .level    (in_cnt)
  );

  msg_fifo #(.W(W_MSG), .DEPTH(DEPTH)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_rdy (i_out_msg_rdy),
    .push_dat (i_out_msg),
    .push_ack (i_out_msg_ack),
    .pop_rdy  (o_out_msg_rdy),
    .pop_dat  (o_out_msg),
    .pop_ack  (o_out_msg_ack),
    .level    (out_cnt)
  );

`ifdef AXI_FIFO_DUMMY_LEVEL_EN
  assign in_level  = in_cnt;
  assign out_level = out_cnt;
`else
  logic [2*cnt_w(DEPTH)-1:0] level_unused;
  assign level_unused = {in_cnt, out_cnt};
`endif

endmodule

// File: tb/tb_axi_fifo_dummy_core.sv
// Bench for axi_fifo_dummy_core: queue-based model checked every cycle plus directed literal checks.
module tb_axi_fifo_dummy_core;
  import axi_fifo_pkg::*;

  localparam int DEPTH = DEPTH_DFLT;
  localparam int CW    = cnt_w(DEPTH);

  logic clk = 1'b0;
  logic rst;
  logic o_in_msg_rdy, o_in_msg_ack, i_in_msg_rdy, i_in_msg_ack;
  logic i_out_msg_rdy, i_out_msg_ack, o_out_msg_rdy, o_out_msg_ack;
  msg_t o_in_msg, i_in_msg, i_out_msg, o_out_msg;
`ifdef AXI_FIFO_DUMMY_LEVEL_EN
  logic [CW-1:0] in_level, out_level;
`endif

  axi_fifo_dummy_core #(.W_MSG(W_MSG_DFLT), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .o_in_msg_rdy  (o_in_msg_rdy),
    .o_in_msg      (o_in_msg),
    .o_in_msg_ack  (o_in_msg_ack),
    .i_in_msg_rdy  (i_in_msg_rdy),
    .i_in_msg      (i_in_msg),
    .i_in_msg_ack  (i_in_msg_ack),
    .i_out_msg_rdy (i_out_msg_rdy),
    .i_out_msg     (i_out_msg),
    .i_out_msg_ack (i_out_msg_ack),
    .o_out_msg_rdy (o_out_msg_rdy),
    .o_out_msg     (o_out_msg),
    .o_out_msg_ack (o_out_msg_ack)
`ifdef AXI_FIFO_DUMMY_LEVEL_EN
    ,
    .in_level      (in_level),
    .out_level     (out_level)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each FIFO is a queue plus "acked last edge" flag
  msg_t qi[$];
  msg_t qo[$];
  bit   ai, ao, pi, po, started;

  always @(posedge clk) begin
    if (rst) begin
      qi.delete();
      qo.delete();
      ai = 1'b0;
      ao = 1'b0;
    end else begin
      pi = o_in_msg_rdy && !ai && (qi.size() < DEPTH);
      po = i_out_msg_rdy && !ao && (qo.size() < DEPTH);
      if (i_in_msg_ack && qi.size() > 0) void'(qi.pop_front());
      if (o_out_msg_ack && qo.size() > 0) void'(qo.pop_front());
      if (pi) qi.push_back(o_in_msg);
      if (po) qo.push_back(i_out_msg);
      ai = pi;
      ao = po;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ack",   o_in_msg_ack,  ai);
      chk("m_in_rdy",   i_in_msg_rdy,  qi.size() > 0);
      chk("m_in_dat",   i_in_msg,      (qi.size() > 0) ? qi[0] : '0);
      chk("m_out_ack",  i_out_msg_ack, ao);
      chk("m_out_rdy",  o_out_msg_rdy, qo.size() > 0);
      chk("m_out_dat",  o_out_msg,     (qo.size() > 0) ? qo[0] : '0);
`ifdef AXI_FIFO_DUMMY_LEVEL_EN
      chk("m_in_lvl",   64'(in_level),  64'(qi.size()));
      chk("m_out_lvl",  64'(out_level), 64'(qo.size()));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input msg_t v);
    o_in_msg_rdy = 1'b1;
    o_in_msg     = v;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_in_msg_ack) break;
    end
    chk("push_in_ack", o_in_msg_ack, 1'b1);
    o_in_msg_rdy = 1'b0;
  endtask

  task automatic pop_in(input msg_t exp, input string name);
    chk(name, i_in_msg, exp);
    i_in_msg_ack = 1'b1;
    step();
    i_in_msg_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    o_in_msg_rdy = 1'b0; o_in_msg = '0; i_in_msg_ack = 1'b0;
    i_out_msg_rdy = 1'b0; i_out_msg = '0; o_out_msg_ack = 1'b0;
    step();
    started = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_in_rdy",  i_in_msg_rdy,  1'b0);
    chk("rst_out_rdy", o_out_msg_rdy, 1'b0);
    chk("rst_in_ack",  o_in_msg_ack,  1'b0);
    chk("rst_out_ack", i_out_msg_ack, 1'b0);
    chk("rst_in_dat",  i_in_msg,      64'h0);
    chk("rst_out_dat", o_out_msg,     64'h0);

    // inbound single message
    o_in_msg_rdy = 1'b1;
    o_in_msg     = 64'h4000_0000_0000_0005;
    step();
    chk("in1_ack", o_in_msg_ack, 1'b1);
    chk("in1_rdy", i_in_msg_rdy, 1'b1);
    chk("in1_dat", i_in_msg,     64'h4000_0000_0000_0005);
    o_in_msg_rdy = 1'b0;
    step();
    chk("in1_ack_pulse", o_in_msg_ack, 1'b0);
    pop_in(64'h4000_0000_0000_0005, "in1_head");
    chk("in1_empty", i_in_msg_rdy, 1'b0);
    chk("in1_zero",  i_in_msg,     64'h0);

    // outbound: rdy held one cycle past ack must not push twice
    i_out_msg_rdy = 1'b1;
    i_out_msg     = 64'h1F5;
    for (int k = 0; k < 20; k++) begin
      step();
      if (i_out_msg_ack) break;
    end
    chk("out_ack_seen", i_out_msg_ack, 1'b1);
    step();
    chk("out_no_dup_ack", i_out_msg_ack, 1'b0);
    i_out_msg_rdy = 1'b0;
    chk("out_rdy", o_out_msg_rdy, 1'b1);
    chk("out_dat", o_out_msg,     64'h1F5);
    o_out_msg_ack = 1'b1;
    step();
    o_out_msg_ack = 1'b0;
    chk("out_empty", o_out_msg_rdy, 1'b0);
    chk("out_zero",  o_out_msg,     64'h0);

    // fill inbound, fifth stalls until a pop
    for (int v = 1; v <= 4; v++) push_in(msg_t'(v));
    o_in_msg_rdy = 1'b1;
    o_in_msg     = 64'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_no_ack", o_in_msg_ack, 1'b0);
    end
    chk("full_head", i_in_msg, 64'd1);
    i_in_msg_ack = 1'b1;
    step();
    i_in_msg_ack = 1'b0;
    chk("full_same_edge_no_ack", o_in_msg_ack, 1'b0);
    chk("full_head_after_pop",   i_in_msg,     64'd2);
    step();
    chk("full_fifth_ack", o_in_msg_ack, 1'b1);
    o_in_msg_rdy = 1'b0;
    for (int v = 2; v <= 5; v++) pop_in(msg_t'(v), "drain_order");
    chk("drain_empty", i_in_msg_rdy, 1'b0);

    // simultaneous push and pop at count 2
    push_in(64'd10);
    push_in(64'd11);
    step();
    o_in_msg_rdy = 1'b1;
    o_in_msg     = 64'd12;
    i_in_msg_ack = 1'b1;
    step();
    o_in_msg_rdy = 1'b0;
    i_in_msg_ack = 1'b0;
    chk("sim_ack",  o_in_msg_ack, 1'b1);
    chk("sim_head", i_in_msg,     64'd11);
`ifdef AXI_FIFO_DUMMY_LEVEL_EN
    chk("sim_level", 64'(in_level), 64'd2);
`endif
    step();
`ifdef AXI_FIFO_DUMMY_LEVEL_EN
    chk("sim_level_hold", 64'(in_level), 64'd2);
`endif
    pop_in(64'd11, "sim_drain");
    pop_in(64'd12, "sim_drain");
    chk("sim_empty", i_in_msg_rdy, 1'b0);

    // reset mid-operation with pushes pending ack
    push_in(64'd20);
    push_in(64'd21);
    step();
    o_in_msg_rdy  = 1'b1;
    o_in_msg      = 64'd22;
    i_out_msg_rdy = 1'b1;
    i_out_msg     = 64'd30;
    step();
    chk("pre_rst_in_ack",  o_in_msg_ack,  1'b1);
    chk("pre_rst_out_ack", i_out_msg_ack, 1'b1);
    rst = 1'b1;
    o_in_msg_rdy  = 1'b0;
    i_out_msg_rdy = 1'b0;
    step();
    chk("mid_rst_in_rdy",  i_in_msg_rdy,  1'b0);
    chk("mid_rst_out_rdy", o_out_msg_rdy, 1'b0);
    chk("mid_rst_in_ack",  o_in_msg_ack,  1'b0);
    chk("mid_rst_out_ack", i_out_msg_ack, 1'b0);
    rst = 1'b0;
    i_in_msg_ack  = 1'b1;
    o_out_msg_ack = 1'b1;
    step();
    i_in_msg_ack  = 1'b0;
    o_out_msg_ack = 1'b0;
    step();
    chk("post_rst_in_rdy",  i_in_msg_rdy,  1'b0);
    chk("post_rst_in_dat",  i_in_msg,      64'h0);
    chk("post_rst_out_rdy", o_out_msg_rdy, 1'b0);
    chk("post_rst_out_dat", o_out_msg,     64'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
